// File: rtl/mlp_acc_pkg.sv
// Shared types and constants for the MLP layer accelerator.
// Elements are signed 16-bit; a row/column is DIM packed elements.
package mlp_acc_pkg;

  localparam int DATA_W = 16;
  localparam int DIM    = 16;
  localparam int ACC_W  = 32;
  localparam int BEATS  = DIM / 2;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [DIM-1:0]          row_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef logic [$clog2(DIM)-1:0]   row_idx_t;
  typedef logic [$clog2(BEATS)-1:0] beat_t;

  typedef enum logic {IDLE, EMIT} state_e;

  typedef struct packed {
    state_e   state;
    row_idx_t row;
    beat_t    beat;
    row_idx_t col;
    logic [2:0] layer;
  } mlp_dbg_t;

  // Sign-extend both operands to the accumulator width; the low ACC_W bits of the
  // product are exact because the true product fits in 32 bits.
  function automatic acc_t mul_ext(elem_t a, elem_t b);
    return acc_t'(a) * acc_t'(b);
  endfunction

endpackage

// File: rtl/mlp_acc_top_dot16.sv
// Combinational signed dot product of two DIM-element rows, summed modulo 2^ACC_W.
module mlp_dot16
  import mlp_acc_pkg::*;
(
  input  row_t a_i,
  input  row_t b_i,
  output acc_t dot_o
);

  acc_t sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < DIM; k++) begin
      sum = sum + mul_ext(a_i[k], b_i[k]);
    end
  end

  assign dot_o = sum;

endmodule

// File: rtl/mlp_acc_top.sv
// MLP layer accelerator: buffers X (16x16) and one W column from a single load port,
// then streams the 16 row dot products after the last weight beat of a column.
module mlp_acc_top
  import mlp_acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en_i,
  input  logic [2*DATA_W-1:0]  load_payload_i,
  input  logic                 load_type_i,
  input  logic [3:0]           input_load_number,
  input  logic [2:0]           layer_number,
  input  logic [2:0]           weight_number,
  output logic                 result_valid_o,
  output logic [ACC_W-1:0]     result_payload_o,
  output mlp_dbg_t             dbg_o
);

  // Load handshake: a beat is taken on any cycle with load_en_i=1 while IDLE; there is
  // no back-pressure, so beats offered during EMIT are discarded.
  state_e   state_q, state_d;
  row_idx_t row_q, row_d;
  beat_t    beat_q, beat_d;
  row_idx_t col_q, col_d;
  logic [2:0] layer_q, layer_d;
  logic     valid_q, valid_d;
  acc_t     result_q, result_d;

  row_t     x_q [DIM];
  row_t     w_q;
  acc_t     dot;

  logic     accept;
  logic     x_we;
  logic     w_we;

  assign accept = load_en_i && (state_q == IDLE);
  assign x_we   = accept && load_type_i;
  assign w_we   = accept && !load_type_i;

  mlp_dot16 u_dot (
    .a_i   (x_q[row_q]),
    .b_i   (w_q),
    .dot_o (dot)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    beat_d   = beat_q;
    col_d    = col_q;
    layer_d  = layer_q;
    valid_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (x_we) begin
          beat_d = beat_q + 1'b1;
        end else if (w_we) begin
          beat_d = '0;
          if (weight_number == beat_t'(BEATS - 1)) begin
            state_d = EMIT;
            row_d   = '0;
            col_d   = input_load_number;
            layer_d = layer_number;
          end
        end
      end
      EMIT: begin
        valid_d  = 1'b1;
        result_d = dot;
        row_d    = row_q + 1'b1;
        if (row_q == row_idx_t'(DIM - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      beat_q   <= '0;
      col_q    <= '0;
      layer_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      beat_q   <= beat_d;
      col_q    <= col_d;
      layer_q  <= layer_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Operand storage persists across columns and layers; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        x_q[r] <= '0;
      end
      w_q <= '0;
    end else begin
      if (x_we) begin
        x_q[input_load_number][{beat_q, 1'b0}] <= load_payload_i[DATA_W-1:0];
        x_q[input_load_number][{beat_q, 1'b1}] <= load_payload_i[2*DATA_W-1:DATA_W];
      end
      if (w_we) begin
        w_q[{weight_number, 1'b0}] <= load_payload_i[DATA_W-1:0];
        w_q[{weight_number, 1'b1}] <= load_payload_i[2*DATA_W-1:DATA_W];
      end
    end
  end

  assign result_valid_o   = valid_q;
  assign result_payload_o = result_q;
  assign dbg_o            = '{state: state_q, row: row_q, beat: beat_q, col: col_q, layer: layer_q};

endmodule

// File: tb/tb_mlp_acc_top.sv
// Directed-plus-random bench for mlp_acc_top against an arithmetic matrix model.
module tb_mlp_acc_top;
  import mlp_acc_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_en_i;
  logic [31:0] load_payload_i;
  logic        load_type_i;
  logic [3:0]  input_load_number;
  logic [2:0]  layer_number;
  logic [2:0]  weight_number;
  logic        result_valid_o;
  logic [31:0] result_payload_o;
  mlp_dbg_t    dbg_o;

  mlp_acc_top dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_en_i         (load_en_i),
    .load_payload_i    (load_payload_i),
    .load_type_i       (load_type_i),
    .input_load_number (input_load_number),
    .layer_number      (layer_number),
    .weight_number     (weight_number),
    .result_valid_o    (result_valid_o),
    .result_payload_o  (result_payload_o),
    .dbg_o             (dbg_o)
  );

  // reference model: the matrices as integers plus the host-visible beat position
  int          x_m [16][16];
  int          w_m [16];
  int          beat_m;
  logic [31:0] exp_q [$];

  logic [15:0] xs [16][16];
  logic [15:0] ws [16];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_dot(input int r);
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(x_m[r][k]) * longint'(w_m[k]);
    return s[31:0];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) x_m[r][k] = 0;
      w_m[r] = 0;
    end
    beat_m = 0;
  endtask

  // driver: one beat presented from a falling edge through the next falling edge
  task automatic drive_beat(input bit typ, input logic [3:0] idx, input logic [2:0] wn,
                            input logic [31:0] pl, input bit dropped);
    load_en_i         = 1'b1;
    load_type_i       = typ;
    input_load_number = idx;
    weight_number     = wn;
    load_payload_i    = pl;
    layer_number      = 3'($urandom_range(0, 7));
    if (!dropped) begin
      if (typ) begin
        x_m[idx][2*beat_m]   = $signed(pl[15:0]);
        x_m[idx][2*beat_m+1] = $signed(pl[31:16]);
        beat_m = (beat_m + 1) % 8;
      end else begin
        w_m[2*wn]   = $signed(pl[15:0]);
        w_m[2*wn+1] = $signed(pl[31:16]);
        beat_m = 0;
        if (wn == 3'd7) begin
          for (int r = 0; r < 16; r++) exp_q.push_back(ref_dot(r));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic load_row(input int r);
    for (int b = 0; b < 8; b++)
      drive_beat(1'b1, 4'(r), 3'd0, {xs[r][2*b+1], xs[r][2*b]}, 1'b0);
  endtask

  task automatic load_x_all();
    for (int r = 0; r < 16; r++) load_row(r);
  endtask

  // weight column; shuffled mode adds a junk write first and a random order before beat 7
  task automatic load_w(input int c, input bit shuffle);
    int ord[8];
    int j, t;
    for (int i = 0; i < 8; i++) ord[i] = i;
    if (shuffle) begin
      drive_beat(1'b0, 4'(c), 3'($urandom_range(0, 6)), $urandom, 1'b0);
      for (int i = 6; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
    for (int i = 0; i < 8; i++)
      drive_beat(1'b0, 4'(c), 3'(ord[i]), {ws[2*ord[i]+1], ws[2*ord[i]]}, 1'b0);
  endtask

  task automatic set_junk();
    load_en_i         = 1'b1;
    load_type_i       = 1'b1;
    input_load_number = 4'($urandom_range(0, 15));
    load_payload_i    = $urandom;
  endtask

  // scoreboard drain for one burst; 'junk' beats are offered on the first EMIT edges
  task automatic collect(input int junk);
    logic [31:0] e;
    logic [31:0] last;
    last = '0;
    if (junk > 0) set_junk(); else load_en_i = 1'b0;
    chk("latency_valid", 32'(result_valid_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i + 1 < junk) set_junk(); else load_en_i = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("valid_r%0d", i), 32'(result_valid_o), 32'd1);
      chk($sformatf("result_r%0d", i), result_payload_o, e);
      last = e;
    end
    @(negedge clk);
    chk("end_valid", 32'(result_valid_o), 32'd0);
    chk("end_hold", result_payload_o, last);
  endtask

  task automatic reset_mid();
    load_en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_r%0d", i), result_payload_o, exp_q.pop_front());
    end
    @(negedge clk);
    chk("rst5_valid", 32'(result_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(result_valid_o), 32'd0);
    chk("rst_async_payload", result_payload_o, 32'd0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(result_valid_o), 32'd0);
  endtask

  task automatic rand_x();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++) xs[r][k] = 16'($urandom_range(0, 65535));
  endtask

  task automatic rand_w();
    for (int k = 0; k < 16; k++) ws[k] = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    load_en_i = 1'b0; load_type_i = 1'b0; input_load_number = '0;
    layer_number = '0; weight_number = '0; load_payload_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(result_valid_o), 32'd0);
    chk("reset_payload", result_payload_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all ones -> 16 each
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) xs[r][k] = 16'd1;
      ws[r] = 16'd1;
    end
    load_x_all(); load_w(0, 1'b0); collect(0);

    // identity with W[k] = k+1
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) xs[r][k] = (r == k) ? 16'd1 : 16'd0;
      ws[r] = 16'(r + 1);
    end
    load_x_all(); load_w(1, 1'b1); collect(0);

    // signed: row0 = -1, W = 3
    for (int k = 0; k < 16; k++) begin xs[0][k] = 16'hFFFF; ws[k] = 16'd3; end
    load_row(0); load_w(2, 1'b1); collect(0);

    // wrap: row0 and W all 0x8000
    for (int k = 0; k < 16; k++) begin xs[0][k] = 16'h8000; ws[k] = 16'h8000; end
    load_row(0); load_w(3, 1'b0); collect(0);

    // a weight beat realigns a half-written row
    for (int b = 0; b < 3; b++) drive_beat(1'b1, 4'd5, 3'd0, $urandom, 1'b0);
    drive_beat(1'b0, 4'd4, 3'd2, $urandom, 1'b0);
    rand_x(); load_row(6); rand_w(); load_w(4, 1'b1); collect(0);

    // random operands, beats offered during EMIT, then the same column again
    rand_x(); rand_w();
    load_x_all(); load_w(5, 1'b1); collect(10);
    load_w(5, 1'b0); collect(0);

    // reset at the fifth result, then a fresh load
    rand_w(); load_w(6, 1'b1); reset_mid();
    rand_x(); rand_w();
    load_x_all(); load_w(7, 1'b1); collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
